// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding an LSB-first serialiser.
// The line idles high and is driven from a register.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQUENCY = 25_000_000,
    parameter int unsigned UART_BAUD_RATE  = 57600,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [7:0]                         data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic                               tx_o,
    output logic                               busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              tx_q, tx_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [7:0]        mem [FIFO_DEPTH];

    logic       push;
    logic       pop;
    logic       baud_done;
    logic [7:0] head;

    assign ready_o   = rst_ni && (count_q < CNT_W'(FIFO_DEPTH));
    assign push      = valid_i && ready_o;
    assign head      = mem[rd_ptr_q];
    assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy_o    = (state_q != StIdle) || (count_q != '0);
    assign count_o   = count_q;
    assign tx_o      = tx_q;

    // FIFO storage; contents are not reset, push already excludes reset via ready_o
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
        end
    end

    // Serialiser next state: tx_d is the level for the coming bit, so tx_o stays registered
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        baud_d    = baud_done ? '0 : baud_q + BAUD_W'(1);
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (count_q != '0) begin
                    shift_d = head;
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (baud_done) begin
                    if (count_q != '0) begin
                        // Back-to-back: next start bit follows the stop bit with no idle gap
                        shift_d = head;
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 10 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_fifo;

    localparam int unsigned CF    = 1000;
    localparam int unsigned BR    = 100;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [9:0] frames [$];
    logic [9:0] mon_frame;
    bit         mon_abort;

    uart_tx_fifo #(
        .CLOCK_FREQUENCY(CF),
        .UART_BAUD_RATE (BR),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (data),
        .valid_i(valid),
        .ready_o(ready),
        .tx_o   (tx),
        .busy_o (busy),
        .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: start 0, data LSB-first, stop 1 (bit j = j-th mid-bit sample)
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] f;
        f = 'x;
        if (frames.size() != 0) f = frames.pop_front();
        check(tag, {22'd0, f}, {22'd0, 1'b1, b, 1'b0});
    endtask

    // Line monitor: on a falling edge, sample 10 bits at mid-bit; drop frames cut by reset
    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_frame = '0;
                for (int j = 0; j < 10 && !mon_abort; j++) begin
                    for (int c = 0; c < ((j == 0) ? 5 : 10) && !mon_abort; c++) begin
                        @(posedge clk);
                        #2;
                        if (rst_n !== 1'b1) mon_abort = 1'b1;
                    end
                    mon_frame[j] = tx;
                end
                if (!mon_abort) frames.push_back(mon_frame);
            end
        end
    end

    initial begin : stim
        // Reset held for 5 cycles
        tick(5);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, ready}, 32'd1);
        tick(1);

        // Single byte 0x41
        valid = 1'b1;
        data  = 8'h41;
        tick(1);
        valid = 1'b0;
        check("single_count", {29'd0, count}, 32'd1);
        check("single_tx_e0", {31'd0, tx}, 32'd1);
        tick(1);
        check("single_tx_fall", {31'd0, tx}, 32'd0);
        tick(99);
        check("single_busy99", {31'd0, busy}, 32'd1);
        tick(1);
        check("single_busy100", {31'd0, busy}, 32'd0);
        check("single_nframes", frames.size(), 32'd1);
        check_frame("single_frame", 8'h41);

        // Back-to-back 0x55, 0xA3
        valid = 1'b1;
        data  = 8'h55;
        tick(1);
        data  = 8'hA3;
        tick(1);
        valid = 1'b0;
        check("b2b_tx_fall", {31'd0, tx}, 32'd0);
        check("b2b_count1", {29'd0, count}, 32'd1);
        tick(100);
        check("b2b_no_gap", {31'd0, tx}, 32'd0);
        check("b2b_count0", {29'd0, count}, 32'd0);
        tick(100);
        check("b2b_busy200", {31'd0, busy}, 32'd0);
        check("b2b_tx_idle", {31'd0, tx}, 32'd1);
        check("b2b_nframes", frames.size(), 32'd2);
        check_frame("b2b_frame0", 8'h55);
        check_frame("b2b_frame1", 8'hA3);

        // Full FIFO: valid held, data advanced on hand-computed accept edges
        valid = 1'b1;
        data  = 8'h01;
        tick(1);
        data  = 8'h02;
        tick(1);
        check("full_tx_fall", {31'd0, tx}, 32'd0);
        data  = 8'h03;
        tick(1);
        data  = 8'h04;
        tick(1);
        data  = 8'h05;
        tick(1);
        data  = 8'h06;
        check("full_count4", {29'd0, count}, 32'd4);
        check("full_ready0", {31'd0, ready}, 32'd0);
        tick(96);
        check("full_hold_count", {29'd0, count}, 32'd4);
        check("full_hold_ready", {31'd0, ready}, 32'd0);
        tick(1);
        check("full_pop_count", {29'd0, count}, 32'd3);
        check("full_pop_ready", {31'd0, ready}, 32'd1);
        tick(1);
        valid = 1'b0;
        check("full_accept6", {29'd0, count}, 32'd4);

        // Push coinciding with a stop-to-start pop at count 3
        tick(99);
        check("sim_pre_count", {29'd0, count}, 32'd3);
        tick(99);
        valid = 1'b1;
        data  = 8'h07;
        tick(1);
        valid = 1'b0;
        check("sim_count", {29'd0, count}, 32'd3);
        check("sim_tx_start", {31'd0, tx}, 32'd0);
        tick(400);
        check("full_drain_busy", {31'd0, busy}, 32'd0);
        check("full_drain_count", {29'd0, count}, 32'd0);
        check("full_nframes", frames.size(), 32'd7);
        for (int i = 1; i <= 7; i++) check_frame("full_frame", 8'(i));

        // Reset during data bit 3 with two bytes queued
        valid = 1'b1;
        data  = 8'h11;
        tick(1);
        data  = 8'h22;
        tick(1);
        data  = 8'h33;
        tick(1);
        valid = 1'b0;
        check("mid_count2", {29'd0, count}, 32'd2);
        tick(43);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_count", {29'd0, count}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 8'h7E;
        tick(1);
        valid = 1'b0;
        check("mid_push_count", {29'd0, count}, 32'd1);
        tick(1);
        check("mid_tx_fall", {31'd0, tx}, 32'd0);
        tick(100);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_nframes", frames.size(), 32'd1);
        check_frame("mid_frame", 8'h7E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that sits directly upstream of the simulation UART receiver. It drives the serial line that the receiver decodes into printable characters. The core-side memory-mapped stdout register pushes bytes into an internal FIFO. The block serialises those bytes LSB-first onto `tx_o` at a fixed baud rate, and exposes a valid/ready push port plus occupancy and busy status.

## Interface
Parameters:
- `CLOCK_FREQUENCY`, 25_000_000: frequency of `clk_i` in Hz.
- `UART_BAUD_RATE`, 57600: line rate in baud.
- `FIFO_DEPTH`, 16: byte entries. Must be a power of two and ≥ 2.
- Derived localparam `CLKS_PER_BIT` = floor(`CLOCK_FREQUENCY` / `UART_BAUD_RATE`). The defaults give 434. Elaboration calls `$fatal` if `CLKS_PER_BIT` < 2.

Ports:
- `clk_i`  in  1  sole clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a byte.
- `tx_o`  out  1  serial line, idle high, registered.
- `busy_o`  out  1  a frame is in flight or the FIFO is non-empty.
- `count_o`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- **Push:** a byte is written at a rising edge where `valid_i && ready_o`.
  - `ready_o` = `rst_ni && (count < FIFO_DEPTH)`, combinational from registered count.
  - `valid_i` while `ready_o` is low is ignored: no write, no error, data lost unless the source holds it.
  - No bypass path; a byte always passes through the FIFO.
- **FIFO:** circular buffer with read and write pointers of log2(FIFO_DEPTH) bits. Pointers wrap modulo `FIFO_DEPTH`.
  - Push only: count +1. Pop only: count −1. Push and pop in the same cycle: count unchanged, both pointers advance.
- **FSM** states: IDLE, START, DATA, STOP.
  - **IDLE:** `tx_o`=1. If FIFO is non-empty: load the head into the shift register, pop, clear the baud counter, set `tx_o`←0, go to START.
  - **START:** hold `tx_o`=0 for `CLKS_PER_BIT` cycles. Then set `tx_o`←shift[0], bit index←0, go to DATA.
  - **DATA:** each bit is held `CLKS_PER_BIT` cycles. At the end of each bit period, shift right and increment the bit index.
    - After bit 7's period: `tx_o`←1, go to STOP.
  - **STOP:** hold `tx_o`=1 for `CLKS_PER_BIT` cycles. At the end of the period:
    - FIFO non-empty: pop the next byte, `tx_o`←0, go to START (back-to-back, no idle gap).
    - FIFO empty: go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`−1 and wraps; its terminal count ends each bit period. Width is $clog2(`CLKS_PER_BIT`).
- `busy_o` = (state ≠ IDLE) || (count ≠ 0).

## Timing
- **Reset** (`rst_ni` low at a rising edge):
  - `tx_o`=1, state=IDLE, count=0, pointers=0, baud counter=0.
  - `ready_o`=0 while `rst_ni` is low; `busy_o`=0.
  - FIFO contents are not reset (don't-care).
- **Reset mid-frame:** the frame is truncated and `tx_o` returns to 1 at that edge. All queued bytes are discarded; the first push after reset starts a fresh frame.
- **Latency, empty and idle:** byte accepted at edge E0 → FIFO count 1 after E0 → `tx_o` falls at E1.
- **Frame timing:**
  - Start bit occupies edges E1..E1+`CLKS_PER_BIT`.
  - Data bit k is driven from E1+(k+1)·`CLKS_PER_BIT`.
  - Stop bit runs from E1+9·`CLKS_PER_BIT`.
  - Frame length is exactly 10·`CLKS_PER_BIT` cycles; the next start bit can begin at E1+10·`CLKS_PER_BIT`.
- **Full FIFO:** `ready_o` is low; it rises in the cycle after the edge at which a pop occurs.
- **Push into an empty FIFO while IDLE:** the pop happens the next cycle, never the same cycle.
- **Baud rounding:** floor division only; a residual baud error of < 1 clock per bit is accepted.

## Test plan
Bench parameters: `CLOCK_FREQUENCY`=1000, `UART_BAUD_RATE`=100 (`CLKS_PER_BIT`=10), `FIFO_DEPTH`=4.
- **Reset:** hold `rst_ni`=0 for 5 cycles → `tx_o`=1, `ready_o`=0, `busy_o`=0, `count_o`=0. Release → `ready_o`=1.
- **Single byte:** push 0x41 → `tx_o` falls 1 cycle later. Sampled at mid-bit the line reads 0,1,0,0,0,0,0,1,0,1. `busy_o` falls 100 cycles after `tx_o` falls.
- **Back-to-back:** push 0x55, 0xA3 on consecutive cycles → two frames, 200 cycles total, no high gap between the stop bit and the second start bit. The bench decodes 0x55 then 0xA3.
- **Full FIFO:** push 6 bytes 0x01–0x06 with `valid_i` held high.
  - The first pops; 4 fill the FIFO, `count_o`=4 and `ready_o`=0.
  - The 6th is accepted only after the first frame's stop bit completes.
  - All 6 bytes are decoded in order.
- **Simultaneous push/pop:** FIFO at count 3, and a push coincides with a STOP→START pop → `count_o` stays 3.
- **Reset mid-frame:** assert reset during data bit 3 with 2 bytes queued → `tx_o`=1 after that edge and `count_o`=0. The next push of 0x7E transmits cleanly and decodes as 0x7E.
